image_stream_tx: RTL and testbench
==================================

// Module: image_stream_tx
// PURPOSE
//  Transmit side of the conv input path. Reads one IMG_WxIMG_H frame of 16-bit pixels from a ping-pong source RAM
//  (bank 0 at addr 0, bank 1 at addr IMG_W*IMG_H) and streams them raster-order over valid/ready with sof/eol/eof marks.
//  Feeds the pixel input of the stride-2 conv/dense pipeline; sustains 1 pixel/cycle while downstream is ready.
// PARAMETERS
//  IMG_W      9   pixels per row
//  IMG_H      9   rows per frame
//  DATA_W     16  pixel width (signed)
//  ADDR_W     10  source RAM address width
//  NUM_BANKS  2   ping-pong banks; bank base = bank*IMG_W*IMG_H
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high
//  start      in   1       begin one frame; sampled only in IDLE
//  busy       out  1       high from cycle after accepted start until done
//  done       out  1       1-cycle pulse after last pixel handshake
//  bank_sel   out  1       bank of current/next frame
//  frame_cnt  out  8       completed frames, wraps 255->0
//  src_en     out  1       source RAM read enable
//  src_addr   out  ADDR_W  source RAM read address
//  src_rdata  in   DATA_W  read data, valid exactly 1 cycle after src_en
//  pix_data   out  DATA_W  pixel
//  pix_valid  out  1       pixel valid
//  pix_ready  in   1       downstream accept; handshake = valid & ready
//  pix_sof    out  1       first pixel of frame (qualified by pix_valid)
//  pix_eol    out  1       last pixel of row
//  pix_eof    out  1       last pixel of frame
// BEHAVIOUR
//  Reset: busy=0, done=0, bank_sel=0, frame_cnt=0, src_en=0, src_addr=0, pix_valid=0, pix_data/sof/eol/eof=0; FSM IDLE;
//   buffer emptied, in-flight read discarded. Reset mid-frame abandons frame: no done, no frame_cnt increment.
//  FSM: IDLE -start-> FETCH; FETCH -last read issued-> DRAIN; DRAIN -last pixel handshake-> DONE; DONE -> IDLE (done=1).
//   start outside IDLE ignored. done and start same cycle impossible (start sampled only in IDLE).
//  Issue: src_en = FETCH & (entries + inflight - pop) < 2, entries in 2-entry output buffer, inflight in {0,1},
//   pop = pix_valid & pix_ready. src_addr = bank_sel*IMG_W*IMG_H + row*IMG_W + col; col wraps at IMG_W-1, row++.
//  Tags (sof/eol/eof) computed at issue, carried with in-flight read, stored with pixel in buffer.
//  Latency: start high cycle 0 -> src_en cycle 1 -> src_rdata cycle 2 -> pix_valid cycle 3.
//  pix_ready held 1: IMG_W*IMG_H consecutive valid cycles, no bubbles.
//  AXI-style hold: once pix_valid=1, pix_data and tags stable until handshake; valid never drops without handshake.
//  Buffer full (2 entries) + ready=0: src_en=0; in-flight always has a free slot by issue rule (no overflow, no loss).
//  done cycle: bank_sel toggles (NUM_BANKS=2; fixed 0 if NUM_BANKS=1), frame_cnt++.
// CONFIGURATION
//  IMG_ZERO_PAD_EN defined: frame is (IMG_W+2)x(IMG_H+2); border positions issue a zero token (src_en=0, still
//   counted as inflight, pushes 0); interior reads src addr of (row-1,col-1). sof/eol/eof refer to padded frame.
//  Undefined: unpadded IMG_WxIMG_H frame as above; no zero tokens.
// STRUCTURE
//  Package img_stream_pkg: pixel_t (logic signed [DATA_W-1:0]), tx_state_e {IDLE,FETCH,DRAIN,DONE},
//   pix_tag_t struct {sof,eol,eof}, localparam FRAME_PIX = IMG_W*IMG_H, bank base helper function.
//  Sub-module img_skid_buf: 2-entry FIFO of {pixel_t, pix_tag_t}, push/pop/count, drives pix_valid/data/tags.
//  Top holds FSM, row/col counters, issue logic, in-flight register, bank/frame counters.
// TESTING
//  Reset: assert 2 cycles -> pix_valid=0, busy=0, done=0, bank_sel=0, frame_cnt=0, src_en=0.
//  Frame 0, RAM[a]=a, ready=1: pixels 0..80 on 81 consecutive cycles, first at cycle 3; sof on 0, eol on 8,17..80,
//   eof on 80; done 1 cycle after, bank_sel->1, frame_cnt=1.
//  Frame 1 with same RAM: pixels 81..161 in order; done -> bank_sel=0, frame_cnt=2.
//  Backpressure: ready pattern 1,0,1,0 then low 6 cycles then 1 -> every pixel once, in order, stable while stalled;
//   src_en never high while entries+inflight=2 and no pop.
//  start pulsed mid-frame ignored (no restart); reset at 40th pixel -> outputs to reset values; next start streams
//   from addr 0, bank 0, no spurious done.
//  IMG_ZERO_PAD_EN: 121 pixels; row 0 = 11 zeros; row 1 = 0,0..8,0; row 10 = 11 zeros; eof on 121st.

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared geometry, types and helpers for the image_stream_tx slice.
// Optional build macro: IMG_ZERO_PAD_EN (adds a one-pixel zero border to every frame).
package img_stream_pkg;

  localparam int IMG_W     = 9;
  localparam int IMG_H     = 9;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int NUM_BANKS = 2;
  localparam int FRAME_PIX = IMG_W * IMG_H;

`ifdef IMG_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  // Geometry of the transmitted frame, which includes the border when padding is built in.
  localparam int FRM_W = IMG_W + 2 * PAD;
  localparam int FRM_H = IMG_H + 2 * PAD;
  localparam int CNT_W = $clog2((FRM_W > FRM_H) ? FRM_W : FRM_H);

  typedef logic signed [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} tx_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  function automatic int bank_base(input logic bank);
    return bank ? FRAME_PIX : 0;
  endfunction

endpackage

// File: rtl/img_skid_buf.sv
// Two-entry output FIFO holding pixels with their frame tags; its head drives the stream.
module img_skid_buf
  import img_stream_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pixel_t     push_data,
  input  pix_tag_t   push_tag,
  input  logic       pop,
  output logic [1:0] count,
  output logic       pix_valid,
  output pixel_t     pix_data,
  output pix_tag_t   pix_tag
);

  typedef struct packed {
    pixel_t   data;
    pix_tag_t tag;
  } entry_t;

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;

  // NOTE: the storage array has no reset; the head is masked by count, so stale contents never leave.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_data, push_tag};
  end

  // NOTE: non-blocking assignments here so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the conditional so no latch is inferred.
    pix_valid = (count != 2'd0);
    pix_data  = '0;
    pix_tag   = '0;
    if (pix_valid) begin
      pix_data = mem[rd_ptr].data;
      pix_tag  = mem[rd_ptr].tag;
    end
  end

endmodule

// File: rtl/image_stream_tx.sv
// Reads one frame from a ping-pong source RAM and streams it raster-order over valid/ready.
// Optional build macro: IMG_ZERO_PAD_EN (frame grows by a zero border; border pixels need no RAM read).
module image_stream_tx
  import img_stream_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bank_sel,
  output logic [7:0]        frame_cnt,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  tx_state_e        state;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             col_last;
  logic             row_last;
  logic             border;
  logic             issue;
  logic             pop;
  logic             inflight;
  logic             inflight_zero;
  logic [1:0]       count;
  logic [2:0]       occupancy;
  pix_tag_t         issue_tag;
  pix_tag_t         inflight_tag;
  pix_tag_t         out_tag;
  pixel_t           push_data;
  pixel_t           out_data;
  int               rd_index;

  always_comb begin
    col_last  = (col == CNT_W'(FRM_W - 1));
    row_last  = (row == CNT_W'(FRM_H - 1));
    pop       = pix_valid & pix_ready;
    // Issue only when the in-flight token is guaranteed a free buffer slot on arrival.
    occupancy = 3'(count) + 3'(inflight) - 3'(pop);
    issue     = (state == FETCH) && (occupancy < 3'd2);
    issue_tag = '{sof: (row == '0) && (col == '0), eol: col_last, eof: col_last && row_last};
`ifdef IMG_ZERO_PAD_EN
    border   = (row == '0) || row_last || (col == '0) || col_last;
    rd_index = border ? 0 : (int'(row) - 1) * IMG_W + int'(col) - 1;
`else
    border   = 1'b0;
    rd_index = int'(row) * IMG_W + int'(col);
`endif
    src_en    = issue && !border;
    src_addr  = ADDR_W'(bank_base(bank_sel) + rd_index);
    push_data = inflight_zero ? pixel_t'(0) : pixel_t'(src_rdata);
    busy      = (state == FETCH) || (state == DRAIN);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      inflight      <= 1'b0;
      inflight_zero <= 1'b0;
      inflight_tag  <= '0;
      bank_sel      <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      inflight      <= issue;
      inflight_zero <= border;
      inflight_tag  <= issue_tag;
      if (issue) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
      end
      case (state)
        IDLE:  if (start) state <= FETCH;
        FETCH: if (issue && col_last && row_last) state <= DRAIN;
        DRAIN: if (pop && out_tag.eof) state <= DONE;
        DONE: begin
          state     <= IDLE;
          frame_cnt <= frame_cnt + 8'd1;
          bank_sel  <= (NUM_BANKS > 1) ? ~bank_sel : 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  img_skid_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .push_tag  (inflight_tag),
    .pop       (pop),
    .count     (count),
    .pix_valid (pix_valid),
    .pix_data  (out_data),
    .pix_tag   (out_tag)
  );

  assign pix_data = out_data;
  assign pix_sof  = out_tag.sof;
  assign pix_eol  = out_tag.eol;
  assign pix_eof  = out_tag.eof;

endmodule

// File: tb/tb_image_stream_tx.sv
// Self-checking bench for image_stream_tx: frame table, backpressure, mid-frame start and reset.
module tb_image_stream_tx;

  localparam int W  = 9;
  localparam int H  = 9;
  localparam int N0 = W * H;
`ifdef IMG_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int FW = W + 2 * PAD;
  localparam int FH = H + 2 * PAD;
  localparam int FN = FW * FH;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pix_ready;
  logic [15:0] src_rdata;
  logic        busy, done, bank_sel, src_en, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [7:0]  frame_cnt;
  logic [9:0]  src_addr;
  logic [15:0] pix_data;

  image_stream_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bank_sel  (bank_sel),
    .frame_cnt (frame_cnt),
    .src_en    (src_en),
    .src_addr  (src_addr),
    .src_rdata (src_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [1024];
  always @(posedge clk) begin
    if (src_en) src_rdata <= ram[src_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  typedef struct {
    int mode;
    bit mid_start;
    bit rand_ram;
    bit exp_bank;
    int exp_cnt;
  } frame_vec_t;

  beat_t got[$];
  int    hs_cyc[$];
  int    done_count = 0;
  int    done_cyc = 0;
  int    outstanding = 0;
  int    start_cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame: raster index i of the (optionally padded) frame read from bank.
  function automatic beat_t exp_beat(input int bank, input int i);
    beat_t b;
    int r = i / FW;
    int c = i % FW;
    b.sof = (i == 0);
    b.eol = (c == FW - 1);
    b.eof = (i == FN - 1);
    if (PAD != 0 && (r == 0 || r == FH - 1 || c == 0 || c == FW - 1))
      b.data = 16'd0;
    else
      b.data = ram[bank * N0 + (r - PAD) * W + (c - PAD)];
    return b;
  endfunction

  // mode 0: always ready; 1: 1,0,1,0, six lows, then ten highs, repeating; 2: random 75%.
  function automatic logic ready_for(input int mode, input int k);
    int idx = k % 20;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx == 0) || (idx == 2) || (idx >= 10);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Stream monitor: collects handshakes, checks hold-while-stalled and the issue room rule.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        mon_beat = {pix_data, pix_sof, pix_eol, pix_eof};
        if (prev_stall) begin
          check("hold_valid", pix_valid, 1);
          check("hold_beat", mon_beat, prev_beat);
        end
`ifndef IMG_ZERO_PAD_EN
        if (src_en) check("issue_room", (outstanding - int'(pix_valid & pix_ready)) < 2, 1);
        outstanding = outstanding + int'(src_en) - int'(pix_valid & pix_ready);
`endif
        if (pix_valid & pix_ready) begin
          got.push_back(mon_beat);
          hs_cyc.push_back(cyc);
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        prev_stall = pix_valid & ~pix_ready;
        prev_beat  = mon_beat;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bank"}, bank_sel, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
    check({tag, "_src_en"}, src_en, 0);
    check({tag, "_src_addr"}, src_addr, 0);
    check({tag, "_data"}, pix_data, 0);
    check({tag, "_tags"}, {pix_sof, pix_eol, pix_eof}, 0);
  endtask

  task automatic run_frame(input int mode, input bit mid_start, input int bank,
                           input bit exp_bank, input int exp_cnt, input string tag);
    int d0 = done_count;
    int k = 0;
    bit finished = 1'b0;
    got.delete();
    hs_cyc.delete();
    start_cyc = cyc;
    while (k < 3000 && !finished) begin
      start     = (k == 0) || (mid_start && k == 30);
      pix_ready = ready_for(mode, k);
      if (k == 10) check({tag, "_busy"}, busy, 1);
      @(posedge clk);
      #1;
      k++;
      finished = (done_count > d0);
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    check({tag, "_done_seen"}, finished, 1);
    check({tag, "_bank_after"}, bank_sel, exp_bank);
    check({tag, "_fcnt_after"}, frame_cnt, exp_cnt);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_count, d0 + 1);
    check({tag, "_pix_count"}, got.size(), FN);
    for (int i = 0; i < got.size() && i < FN; i++)
      check($sformatf("%s_pix%0d", tag, i), got[i], exp_beat(bank, i));
    if (hs_cyc.size() > 0) begin
      if (mode == 0) begin
        check({tag, "_first_latency"}, hs_cyc[0] - start_cyc, 3);
        check({tag, "_no_bubbles"}, hs_cyc[hs_cyc.size() - 1] - hs_cyc[0], FN - 1);
      end
      check({tag, "_done_timing"}, done_cyc, hs_cyc[hs_cyc.size() - 1] + 1);
    end
  endtask

  frame_vec_t vecs[5];
  int model_bank;
  int d_before;
  int k;

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 1};
    vecs[1] = '{0, 1'b0, 1'b0, 1'b0, 2};
    vecs[2] = '{1, 1'b0, 1'b0, 1'b1, 3};
    vecs[3] = '{2, 1'b1, 1'b1, 1'b0, 4};
    vecs[4] = '{2, 1'b0, 1'b1, 1'b1, 5};

    for (int a = 0; a < 1024; a++) ram[a] = 16'(a);
    reset     = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    pix_ready = 1'b1;
    @(posedge clk);
    #1;

    model_bank = 0;
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rand_ram)
        for (int a = 0; a < 2 * N0; a++) ram[a] = 16'($urandom);
      run_frame(vecs[v].mode, vecs[v].mid_start, model_bank, vecs[v].exp_bank,
                vecs[v].exp_cnt, $sformatf("frame%0d", v));
      model_bank = 1 - model_bank;
    end

    // Abandon a frame at its 40th pixel with reset, then restart from bank 0.
    for (int a = 0; a < 1024; a++) ram[a] = 16'(a);
    d_before = done_count;
    got.delete();
    hs_cyc.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (got.size() < 40 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_reached_40", got.size() >= 40, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_no_done", done_count, d_before);
    @(posedge clk);
    #1;
    run_frame(0, 1'b0, 0, 1'b1, 1, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
